// File: rtl/hold_delay_pkg.sv
// Shared sizing helpers and parameter-legality rules for the hold delay line.
package hold_delay_pkg;

    localparam int unsigned MinWidth = 1;
    localparam int unsigned MinDepth = 1;
    localparam int unsigned MinHold  = 1;

    function automatic int unsigned cnt_w(input int unsigned hold);
        return (hold <= 1) ? 1 : $clog2(hold);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned depth,
                                     input int unsigned hold, input int unsigned phase);
        return (width >= MinWidth) && (depth >= MinDepth) && (hold >= MinHold) &&
               (phase < hold);
    endfunction

endpackage

// File: rtl/hold_phase_gen.sv
// Phase counter for the hold delay line; decodes the capture strobe at PHASE.
module hold_phase_gen
    import hold_delay_pkg::*;
#(
    parameter int unsigned HOLD  = 2,
    parameter int unsigned PHASE = 0
) (
    input  logic                      pll_clock,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      flush,
    output logic                      cap,
    output logic [cnt_w(HOLD)-1:0]    phase
);

    localparam int unsigned CntW = cnt_w(HOLD);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CntW'(HOLD - 1)) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cap   = en & (cnt_q == CntW'(PHASE)) & ~flush;
    assign phase = cnt_q;

endmodule

// File: rtl/hold_delay_line.sv
// Sample-and-hold delay line: captures data_in once per HOLD cycles and shifts it
// through DEPTH individually registered stages.
module hold_delay_line
    import hold_delay_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned HOLD  = 2,
    parameter int unsigned PHASE = 0
) (
    input  logic                      pll_clock,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      out_new,
    output logic                      out_valid,
    output logic [cnt_w(HOLD)-1:0]    phase
);

    localparam int unsigned FillW = $clog2(DEPTH + 1);

    if (!params_ok(WIDTH, DEPTH, HOLD, PHASE)) begin : g_param_check
        $error("hold_delay_line: illegal parameters (need DEPTH>=1, HOLD>=1, PHASE<HOLD)");
    end

    logic             cap;
    logic [FillW-1:0] fill_q, fill_d;
    logic             out_new_q;

    hold_phase_gen #(
        .HOLD  (HOLD),
        .PHASE (PHASE)
    ) u_phase_gen (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .en        (en),
        .flush     (flush),
        .cap       (cap),
        .phase     (phase)
    );

    // One register per stage with async reset, so no stage can collapse into an SRL/RAM.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] d;

        if (i == 0) begin : g_head
            assign d = data_in;
        end else begin : g_tail
            assign d = g_stage[i-1].q;
        end

        always_ff @(posedge pll_clock or negedge reset_n) begin
            if (!reset_n) begin
                q <= '0;
            end else if (flush) begin
                q <= '0;
            end else if (cap) begin
                q <= d;
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (cap && (fill_q != FillW'(DEPTH))) begin
            fill_d = fill_q + FillW'(1);
        end
    end

    always_ff @(posedge pll_clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_q    <= '0;
            out_new_q <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            out_new_q <= cap & ~flush;
        end
    end

    assign data_out  = g_stage[DEPTH-1].q;
    assign out_new   = out_new_q;
    assign out_valid = (fill_q == FillW'(DEPTH));

endmodule

// File: tb/tb_hold_delay_line.sv
// Two hold_delay_line configurations driven in lockstep against an arithmetic model.
module tb_hold_delay_line;

    logic       pll_clock = 1'b0;
    logic       reset_n;
    logic       en;
    logic       flush;
    logic [7:0] data_in;

    logic [7:0] d0_out, d1_out;
    logic       d0_new, d1_new, d0_valid, d1_valid;
    logic       d0_phase;
    logic [1:0] d1_phase;

    int n_checks = 0;
    int n_errors = 0;

    always #5 pll_clock = ~pll_clock;

    hold_delay_line #(.WIDTH(8), .DEPTH(2), .HOLD(2), .PHASE(0)) u_dut0 (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .en        (en),
        .flush     (flush),
        .data_in   (data_in),
        .data_out  (d0_out),
        .out_new   (d0_new),
        .out_valid (d0_valid),
        .phase     (d0_phase)
    );

    hold_delay_line #(.WIDTH(8), .DEPTH(1), .HOLD(4), .PHASE(3)) u_dut1 (
        .pll_clock (pll_clock),
        .reset_n   (reset_n),
        .en        (en),
        .flush     (flush),
        .data_in   (data_in),
        .data_out  (d1_out),
        .out_new   (d1_new),
        .out_valid (d1_valid),
        .phase     (d1_phase)
    );

    // Model: k = enabled edges since reset/flush, words_m = every captured word in order.
    int         hold_m [2] = '{2, 4};
    int         phs_m  [2] = '{0, 3};
    int         depth_m[2] = '{2, 1};
    int         k_m    [2];
    int         caps_m [2];
    bit         new_m  [2];
    logic [7:0] words_m[2][4096];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k_m[i]    = 0;
            caps_m[i] = 0;
            new_m[i]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (flush) begin
                model_reset_one(i);
            end else begin
                new_m[i] = en && ((k_m[i] % hold_m[i]) == phs_m[i]);
                if (new_m[i]) begin
                    words_m[i][caps_m[i]] = data_in;
                    caps_m[i]++;
                end
                if (en) k_m[i]++;
            end
        end
    endtask

    task automatic model_reset_one(input int i);
        k_m[i]    = 0;
        caps_m[i] = 0;
        new_m[i]  = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input int i);
        if (caps_m[i] >= depth_m[i]) return 32'(words_m[i][caps_m[i] - depth_m[i]]);
        return 32'd0;
    endfunction

    function automatic logic [31:0] exp_valid(input int i);
        return (caps_m[i] >= depth_m[i]) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("d0_data",  32'(d0_out),   exp_data(0));
        check("d0_valid", 32'(d0_valid), exp_valid(0));
        check("d0_new",   32'(d0_new),   32'(new_m[0]));
        check("d0_phase", 32'(d0_phase), 32'(k_m[0] % hold_m[0]));
        check("d1_data",  32'(d1_out),   exp_data(1));
        check("d1_valid", 32'(d1_valid), exp_valid(1));
        check("d1_new",   32'(d1_new),   32'(new_m[1]));
        check("d1_phase", 32'(d1_phase), 32'(k_m[1] % hold_m[1]));
    endtask

    task automatic step();
        @(posedge pll_clock);
        model_step();
        @(negedge pll_clock);
        compare_all();
    endtask

    task automatic random_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            en      = ($urandom_range(0, 9) != 0);
            flush   = ($urandom_range(0, 29) == 0);
            data_in = 8'($urandom);
            step();
        end
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        flush   = 1'b0;
        data_in = 8'h00;
        model_reset();
        repeat (2) @(negedge pll_clock);
        compare_all();
        check("rst_d0_data", 32'(d0_out), 32'h0);
        check("rst_d0_valid", 32'(d0_valid), 32'h0);
        reset_n = 1'b1;

        // Incrementing data from 0x10, en held high.
        for (int n = 1; n <= 12; n++) begin
            en      = 1'b1;
            data_in = 8'(8'h10 + n - 1);
            step();
            check("inc_d0_new", 32'(d0_new), (n % 2 == 1) ? 32'd1 : 32'd0);
            if (n <= 4) check("inc_d1_phase", 32'(d1_phase), 32'(n % 4));
            if (n == 3) begin
                check("inc_d0_first", 32'(d0_out), 32'h10);
                check("inc_d0_valid", 32'(d0_valid), 32'd1);
            end
            if (n == 4) begin
                check("inc_d0_hold", 32'(d0_out), 32'h10);
                check("inc_d1_first", 32'(d1_out), 32'h13);
                check("inc_d1_new", 32'(d1_new), 32'd1);
            end
            if (n == 5) check("inc_d0_next", 32'(d0_out), 32'h12);
        end

        // en low for 3 cycles mid-hold, then resume.
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (4) step();

        // Prime with 0x33 then flush with en high.
        data_in = 8'h33;
        repeat (6) step();
        check("pre_flush_data", 32'(d0_out), 32'h33);
        flush = 1'b1;
        step();
        check("flush_data",  32'(d0_out),   32'h0);
        check("flush_valid", 32'(d0_valid), 32'h0);
        check("flush_phase", 32'(d0_phase), 32'h0);
        check("flush_new",   32'(d0_new),   32'h0);
        check("flush_d1_new", 32'(d1_new),  32'h0);
        flush = 1'b0;
        repeat (6) step();

        random_run(700);

        // Asynchronous reset pulse between edges.
        @(negedge pll_clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_d0_data",  32'(d0_out),   32'h0);
        check("arst_d0_valid", 32'(d0_valid), 32'h0);
        check("arst_d0_phase", 32'(d0_phase), 32'h0);
        check("arst_d0_new",   32'(d0_new),   32'h0);
        check("arst_d1_data",  32'(d1_out),   32'h0);
        check("arst_d1_valid", 32'(d1_valid), 32'h0);
        check("arst_d1_phase", 32'(d1_phase), 32'h0);
        check("arst_d1_new",   32'(d1_new),   32'h0);
        model_reset();
        #1 reset_n = 1'b1;

        random_run(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
